// File: rtl/tokens_pkg.sv
// Shared constants and types for the token path (doubler and halver sides).
package tokens_pkg;

    // Default depth of the pending output-token buffer.
    localparam int TOK_MAX_PEND = 200;

    // Default number of idle cycles before a partial group is dropped.
    localparam int TOK_TIMEOUT  = 16;

    // Group collector state: IDLE means no tokens of the current group seen yet.
    typedef enum logic {
        IDLE    = 1'b0,
        PARTIAL = 1'b1
    } tok_phase_state_t;

endpackage

// File: rtl/token_group_counter.sv
// Counts input tokens modulo RATIO and flags each completed group.
// A group left incomplete for TIMEOUT idle cycles is discarded. stale is
// high in the cycle where the idle timer sits at TIMEOUT. The clear happens
// on the following edge, and a token arriving on that edge is dropped together
// with the partial group.
module token_group_counter
    import tokens_pkg::*;
#(
    parameter int RATIO   = 2,
    parameter int TIMEOUT = TOK_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic group_done,
    output logic stale
);

    localparam int PH_W = $clog2(RATIO);
    localparam int TM_W = $clog2(TIMEOUT + 1);

    localparam logic [PH_W-1:0] PH_ZERO = {PH_W{1'b0}};
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(RATIO - 1);
    localparam logic [TM_W-1:0] TM_ZERO = {TM_W{1'b0}};
    localparam logic [TM_W-1:0] TM_ONE  = TM_W'(1);
    localparam logic [TM_W-1:0] TM_MAX  = TM_W'(TIMEOUT);

    tok_phase_state_t  state_r, state_nx_s;
    logic [PH_W-1:0]   phase_r, phase_nx_s;
    logic [TM_W-1:0]   timer_r, timer_nx_s;
    logic              stale_r, stale_nx_s;
    logic              group_done_s;

    // Next-state, phase, timer and completion decode.
    always_comb begin
        state_nx_s   = state_r;
        phase_nx_s   = phase_r;
        timer_nx_s   = timer_r;
        group_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                timer_nx_s = TM_ZERO;
                if (a) begin
                    // RATIO >= 2, so the first token of a group never completes it.
                    phase_nx_s = PH_ONE;
                    state_nx_s = PARTIAL;
                end else begin
                    phase_nx_s = PH_ZERO;
                end
            end
            PARTIAL: begin
                if (stale_r) begin
                    // Timeout wins over any token on this edge.
                    phase_nx_s = PH_ZERO;
                    timer_nx_s = TM_ZERO;
                    state_nx_s = IDLE;
                end else if (a) begin
                    timer_nx_s = TM_ZERO;
                    if (phase_r == PH_LAST) begin
                        group_done_s = 1'b1;
                        phase_nx_s   = PH_ZERO;
                        state_nx_s   = IDLE;
                    end else begin
                        phase_nx_s = phase_r + PH_ONE;
                    end
                end else begin
                    // Cannot wrap: the cycle after reaching TM_MAX always clears.
                    timer_nx_s = timer_r + TM_ONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
                phase_nx_s = PH_ZERO;
                timer_nx_s = TM_ZERO;
            end
        endcase
        stale_nx_s = (state_nx_s == PARTIAL) && (timer_nx_s == TM_MAX);
    end

    // State, phase, timer and stale flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            phase_r <= PH_ZERO;
            timer_r <= TM_ZERO;
            stale_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            phase_r <= phase_nx_s;
            timer_r <= timer_nx_s;
            stale_r <= stale_nx_s;
        end
    end

    assign group_done = group_done_s;
    assign stale      = stale_r;

endmodule

// File: rtl/halve_tokens.sv
// Token-stream rate divider: one output token per RATIO input tokens, held
// in a saturating credit counter and drained through a valid/ready handshake.
module halve_tokens
    import tokens_pkg::*;
#(
    parameter int RATIO    = 2,
    parameter int MAX_PEND = TOK_MAX_PEND,
    parameter int TIMEOUT  = TOK_TIMEOUT,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] level,
    output logic             overflow,
    output logic             stale
);

    // Elaboration-time parameter legality checks.
    if ((RATIO < 2) || (RATIO > 16)) begin : g_chk_ratio
        $error("halve_tokens: RATIO must be in 2..16");
    end
    if (TIMEOUT < 1) begin : g_chk_timeout
        $error("halve_tokens: TIMEOUT must be at least 1");
    end
    if ((64'd1 << CNT_W) <= 64'(MAX_PEND)) begin : g_chk_cnt_w
        $error("halve_tokens: CNT_W too narrow for MAX_PEND");
    end

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_PEND);

    logic             group_done_s;
    logic             pop_s;
    logic [CNT_W-1:0] pending_r, pending_nx_s;
    logic             overflow_r, overflow_nx_s;

    token_group_counter #(
        .RATIO   (RATIO),
        .TIMEOUT (TIMEOUT)
    ) u_group (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .group_done (group_done_s),
        .stale      (stale)
    );

    assign pop_s = (pending_r != CNT_ZERO) && b_ready;

    // Credit counter update: push on completion, pop on handshake, saturate at full.
    always_comb begin
        pending_nx_s  = pending_r;
        overflow_nx_s = overflow_r;
        case ({group_done_s, pop_s})
            2'b10: begin
                if (pending_r == CNT_MAX) begin
                    overflow_nx_s = 1'b1;
                end else begin
                    pending_nx_s = pending_r + CNT_ONE;
                end
            end
            2'b01: begin
                pending_nx_s = pending_r - CNT_ONE;
            end
            2'b11: begin
                // Push and pop cancel, including when the buffer is full.
                pending_nx_s = pending_r;
            end
            default: begin
                pending_nx_s = pending_r;
            end
        endcase
    end

    // Pending count and sticky overflow registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_r  <= CNT_ZERO;
            overflow_r <= 1'b0;
        end else begin
            pending_r  <= pending_nx_s;
            overflow_r <= overflow_nx_s;
        end
    end

    assign b_valid  = (pending_r != CNT_ZERO);
    assign level    = pending_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_halve_tokens.sv
// Directed bench for halve_tokens: a default instance (RATIO=2, MAX_PEND=200,
// TIMEOUT=16) and a small instance with MAX_PEND=4 for saturation behaviour.
module tb_halve_tokens;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       a = 1'b0;
    logic       b_ready = 1'b0;
    logic       b_valid;
    logic [7:0] level;
    logic       overflow;
    logic       stale;

    logic       a2 = 1'b0;
    logic       b_ready2 = 1'b0;
    logic       b_valid2;
    logic [7:0] level2;
    logic       overflow2;
    logic       stale2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    halve_tokens dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .level    (level),
        .overflow (overflow),
        .stale    (stale)
    );

    halve_tokens #(.MAX_PEND(4)) dut_sm (
        .clk      (clk),
        .rst      (rst),
        .a        (a2),
        .b_valid  (b_valid2),
        .b_ready  (b_ready2),
        .level    (level2),
        .overflow (overflow2),
        .stale    (stale2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; a = 1'b1; a2 = 1'b1; b_ready = 1'b0; b_ready2 = 1'b0;
        step(); step();
        checks++;
        if ({b_valid, level, overflow, stale} !== 11'd0) begin
            errors++; $display("FAIL reset_outputs got v=%b l=%0d o=%b s=%b want all 0", b_valid, level, overflow, stale);
        end
        checks++;
        if ({b_valid2, level2, overflow2, stale2} !== 11'd0) begin
            errors++; $display("FAIL reset_outputs_sm got v=%b l=%0d o=%b s=%b want all 0", b_valid2, level2, overflow2, stale2);
        end
        a = 1'b0; a2 = 1'b0; rst = 1'b1;
        step();
    endtask

    task automatic test_fill();
        int exp_lvl[6] = '{0, 1, 1, 2, 2, 3};
        a = 1'b1; b_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (level !== 8'(exp_lvl[i])) begin
                errors++; $display("FAIL fill_level[%0d] got %0d want %0d", i, level, exp_lvl[i]);
            end
        end
        a = 1'b0;
        checks++;
        if ({b_valid, overflow, stale} !== 3'b100) begin
            errors++; $display("FAIL fill_flags got v=%b o=%b s=%b want 1 0 0", b_valid, overflow, stale);
        end
    endtask

    task automatic test_pops();
        int exp_lvl[3] = '{2, 1, 0};
        a = 1'b0; b_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (level !== 8'(exp_lvl[i])) begin
                errors++; $display("FAIL pop_level[%0d] got %0d want %0d", i, level, exp_lvl[i]);
            end
            checks++;
            if (b_valid !== (i < 2)) begin
                errors++; $display("FAIL pop_valid[%0d] got %b want %b", i, b_valid, (i < 2));
            end
        end
        // Ready while empty must not underflow.
        step();
        checks++;
        if (level !== 8'd0 || b_valid !== 1'b0) begin
            errors++; $display("FAIL pop_empty got l=%0d v=%b want 0 0", level, b_valid);
        end
        b_ready = 1'b0;
    endtask

    task automatic test_timeout();
        a = 1'b1; step(); a = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            checks++;
            if (stale !== (k == 16)) begin
                errors++; $display("FAIL timeout_stale[%0d] got %b want %b", k, stale, (k == 16));
            end
        end
        step();
        checks++;
        if (stale !== 1'b0 || level !== 8'd0) begin
            errors++; $display("FAIL timeout_after got s=%b l=%0d want 0 0", stale, level);
        end
        // Phase must be back at 0: one token gives nothing, the second completes.
        a = 1'b1; step();
        checks++;
        if (level !== 8'd0) begin
            errors++; $display("FAIL timeout_phase1 got %0d want 0", level);
        end
        step();
        checks++;
        if (level !== 8'd1) begin
            errors++; $display("FAIL timeout_phase2 got %0d want 1", level);
        end
        a = 1'b0; b_ready = 1'b1; step(); b_ready = 1'b0;
        checks++;
        if (level !== 8'd0) begin
            errors++; $display("FAIL timeout_drain got %0d want 0", level);
        end
    endtask

    task automatic test_timeout_priority();
        a = 1'b1; step(); a = 1'b0;
        for (int k = 1; k <= 16; k++) step();
        checks++;
        if (stale !== 1'b1) begin
            errors++; $display("FAIL prio_stale got %b want 1", stale);
        end
        // Token on the timeout edge is dropped with the partial group.
        a = 1'b1; step();
        checks++;
        if (level !== 8'd0 || stale !== 1'b0) begin
            errors++; $display("FAIL prio_drop got l=%0d s=%b want 0 0", level, stale);
        end
        step();
        checks++;
        if (level !== 8'd0) begin
            errors++; $display("FAIL prio_next1 got %0d want 0", level);
        end
        step();
        checks++;
        if (level !== 8'd1) begin
            errors++; $display("FAIL prio_next2 got %0d want 1", level);
        end
        a = 1'b0; b_ready = 1'b1; step(); b_ready = 1'b0;
    endtask

    task automatic test_simul();
        a = 1'b1;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (level !== 8'd2) begin
            errors++; $display("FAIL simul_setup got %0d want 2", level);
        end
        step();
        b_ready = 1'b1; step();
        checks++;
        if (level !== 8'd2 || b_valid !== 1'b1) begin
            errors++; $display("FAIL simul_push_pop got l=%0d v=%b want 2 1", level, b_valid);
        end
        a = 1'b0; b_ready = 1'b0;
    endtask

    task automatic test_overflow();
        a2 = 1'b1; b_ready2 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 8) begin
                checks++;
                if (level2 !== 8'd4 || overflow2 !== 1'b0) begin
                    errors++; $display("FAIL ovf_full got l=%0d o=%b want 4 0", level2, overflow2);
                end
            end
        end
        checks++;
        if (level2 !== 8'd4 || overflow2 !== 1'b1) begin
            errors++; $display("FAIL ovf_set got l=%0d o=%b want 4 1", level2, overflow2);
        end
        // Pop with a=1 (phase 0, so no completion).
        b_ready2 = 1'b1; step(); b_ready2 = 1'b0;
        checks++;
        if (level2 !== 8'd3 || overflow2 !== 1'b1) begin
            errors++; $display("FAIL ovf_pop got l=%0d o=%b want 3 1", level2, overflow2);
        end
        step();
        checks++;
        if (level2 !== 8'd4) begin
            errors++; $display("FAIL ovf_refill got %0d want 4", level2);
        end
        step(); step();
        checks++;
        if (level2 !== 8'd4 || overflow2 !== 1'b1) begin
            errors++; $display("FAIL ovf_drop got l=%0d o=%b want 4 1", level2, overflow2);
        end
        // Completion together with a pop at full is accepted.
        step();
        b_ready2 = 1'b1; step(); b_ready2 = 1'b0;
        checks++;
        if (level2 !== 8'd4) begin
            errors++; $display("FAIL ovf_push_pop_full got %0d want 4", level2);
        end
        a2 = 1'b0;
    endtask

    task automatic test_reset_mid();
        a = 1'b1;
        for (int i = 0; i < 396; i++) step();
        checks++;
        if (level !== 8'd200 || overflow !== 1'b0) begin
            errors++; $display("FAIL mid_fill got l=%0d o=%b want 200 0", level, overflow);
        end
        step(); step();
        checks++;
        if (level !== 8'd200 || overflow !== 1'b1) begin
            errors++; $display("FAIL mid_ovf got l=%0d o=%b want 200 1", level, overflow);
        end
        a = 1'b0; b_ready = 1'b1;
        for (int i = 0; i < 195; i++) step();
        b_ready = 1'b0; a = 1'b1; step();
        checks++;
        if (level !== 8'd5 || overflow !== 1'b1) begin
            errors++; $display("FAIL mid_setup got l=%0d o=%b want 5 1", level, overflow);
        end
        rst = 1'b0; step(); rst = 1'b1;
        checks++;
        if ({b_valid, level, overflow, stale} !== 11'd0) begin
            errors++; $display("FAIL mid_reset got v=%b l=%0d o=%b s=%b want all 0", b_valid, level, overflow, stale);
        end
        step();
        checks++;
        if (level !== 8'd0) begin
            errors++; $display("FAIL mid_tok1 got %0d want 0", level);
        end
        step(); a = 1'b0;
        checks++;
        if (level !== 8'd1 || b_valid !== 1'b1) begin
            errors++; $display("FAIL mid_tok2 got l=%0d v=%b want 1 1", level, b_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_pops();
        test_timeout();
        test_timeout_priority();
        test_simul();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
